// File: rtl/over_screen_ctrl_pkg.sv
// over_pkg: shared types and constants for the game-over overlay.
//   over_state_t : overlay sequencing states
//   FADE_MAX     : full-brightness fade level (level range 0..FADE_MAX)
//   LEVEL_W      : width of a fade level
//   rgb12_t      : 4:4:4 colour as {r,g,b}
package over_pkg;
  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} over_state_t;

  localparam int FADE_MAX = 16;
  localparam int LEVEL_W  = 5;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;
endpackage

// File: rtl/over_fade_scale.sv
// over_fade_scale: purely combinational brightness scaler.
//   rgb    in  rgb12_t        colour to scale
//   level  in  LEVEL_W bits   fade level 0..16
//   scaled out rgb12_t        each channel = (c * level) >> 4
// Level 16 reproduces the input exactly; level 0 gives black.
module over_fade_scale
  import over_pkg::*;
(
  input  rgb12_t             rgb,
  input  logic [LEVEL_W-1:0] level,
  output rgb12_t             scaled
);

  // 4b * 5b fits in 8 bits because level never exceeds 16 (15*16 = 240).
  function automatic logic [3:0] scale4(input logic [3:0] c, input logic [LEVEL_W-1:0] lv);
    logic [7:0] p;
    p = 8'(c) * 8'(lv);
    return p[7:4];
  endfunction

  assign scaled.r = scale4(rgb.r, level);
  assign scaled.g = scale4(rgb.g, level);
  assign scaled.b = scale4(rgb.b, level);

endmodule

// File: rtl/over_screen_ctrl.sv
// over_screen_ctrl: game-over overlay sequencer and pixel pipeline.
//   Clk, Reset          pixel clock, async active-high reset
//   game_over           level from the game FSM (edges are detected here)
//   restart_key         one-cycle keypress, honoured only in HOLD
//   frame_start         one-cycle pulse per frame; all fade/blink timing counts these
//   DrawX, DrawY        scan position
//   rom_addr / rom_data sprite ROM (synchronous, 1-cycle read)
//   pal_index / pal_rgb combinational palette lookup
//   over_red/green/blue faded overlay colour, 0 when not active
//   over_active         overlay pixel is opaque
//   restart_req         one-cycle pulse when fade-out completes
// Pixel path latency is 3 cycles: S1 window/address, S2 ROM data + palette,
// S3 registered scaled colour.
// Build option: define OVER_BLINK_EN to make HOLD blink; otherwise HOLD is steady.
module over_screen_ctrl
  import over_pkg::*;
#(
  parameter int IMG_W            = 256,
  parameter int IMG_H            = 64,
  parameter int X0               = 192,
  parameter int Y0               = 208,
  parameter int FADE_STEP_FRAMES = 4,
  parameter int BLINK_FRAMES     = 30,
  parameter int TRANSPARENT_IDX  = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        game_over,
  input  logic        restart_key,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [13:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  pal_index,
  input  logic [11:0] pal_rgb,
  output logic [3:0]  over_red,
  output logic [3:0]  over_green,
  output logic [3:0]  over_blue,
  output logic        over_active,
  output logic        restart_req
);

  localparam logic [10:0] XL = 11'(X0);
  localparam logic [10:0] XH = 11'(X0 + IMG_W);
  localparam logic [10:0] YL = 11'(Y0);
  localparam logic [10:0] YH = 11'(Y0 + IMG_H);

  localparam int               STEP_W    = $clog2(FADE_STEP_FRAMES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);

  // ---------------- S1: window test and ROM address ----------------
  logic [10:0] x, y, dx, dy;
  logic        win;
  logic [13:0] addr_c;

  assign x      = {1'b0, DrawX};
  assign y      = {1'b0, DrawY};
  assign dx     = x - XL;
  assign dy     = y - YL;
  assign win    = (x >= XL) && (x < XH) && (y >= YL) && (y < YH);
  assign addr_c = win ? 14'(32'(dy) * IMG_W + 32'(dx)) : '0;

  // win_pipe[0] aligns with rom_addr, win_pipe[1] with rom_data.
  logic [1:0] win_pipe;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      win_pipe <= '0;
    end else begin
      rom_addr <= addr_c;
      win_pipe <= {win_pipe[0], win};
    end
  end

  // ---------------- Sequencer ----------------
  over_state_t        state, state_n;
  logic [LEVEL_W-1:0] level, level_n;
  logic [STEP_W-1:0]  step_cnt, step_n;
  logic               go_q, go_rise, go_fall, req_n;

  assign go_rise = game_over & ~go_q;
  assign go_fall = ~game_over & go_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      level       <= '0;
      step_cnt    <= '0;
      go_q        <= 1'b0;
      restart_req <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      step_cnt    <= step_n;
      go_q        <= game_over;
      restart_req <= req_n;
    end
  end

  // Any state change clears step_cnt and swallows a coincident frame_start.
  always_comb begin
    state_n = state;
    level_n = level;
    step_n  = step_cnt;
    req_n   = 1'b0;
    case (state)
      IDLE: begin
        if (go_rise) begin
          state_n = FADE_IN;
          level_n = '0;
          step_n  = '0;
        end
      end
      FADE_IN: begin
        if (go_fall) begin
          state_n = FADE_OUT;
          step_n  = '0;
        end else if (frame_start) begin
          if (step_cnt == STEP_LAST) begin
            step_n = '0;
            if (level >= LEVEL_W'(FADE_MAX - 1)) begin
              level_n = LEVEL_W'(FADE_MAX);
              state_n = HOLD;
            end else begin
              level_n = level + 1'b1;
            end
          end else begin
            step_n = step_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        level_n = LEVEL_W'(FADE_MAX);
        if (restart_key || go_fall) begin
          state_n = FADE_OUT;
          step_n  = '0;
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          if (step_cnt == STEP_LAST) begin
            step_n = '0;
            // Saturate at 0: a fade-out starting at 0 still waits one step.
            if (level <= LEVEL_W'(1)) begin
              level_n = '0;
              state_n = IDLE;
              req_n   = 1'b1;
            end else begin
              level_n = level - 1'b1;
            end
          end else begin
            step_n = step_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        level_n = '0;
        step_n  = '0;
      end
    endcase
  end

  // ---------------- Blink ----------------
  logic blink_on;
`ifdef OVER_BLINK_EN
  localparam int                BLINK_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  logic [BLINK_W-1:0] blink_cnt;

  // Phase restarts "on" at HOLD entry and is forced on when leaving HOLD.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state != HOLD || state_n != HOLD) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif

  // ---------------- S2/S3: palette and fade ----------------
  rgb12_t pal_c, scaled;
  logic   act_n;

  assign pal_index = rom_data;
  assign pal_c     = pal_rgb;

  over_fade_scale u_scale (
    .rgb    (pal_c),
    .level  (level),
    .scaled (scaled)
  );

  assign act_n = win_pipe[1] && (state != IDLE) &&
                 (rom_data != 4'(TRANSPARENT_IDX)) && blink_on;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      over_active <= 1'b0;
      over_red    <= '0;
      over_green  <= '0;
      over_blue   <= '0;
    end else begin
      over_active <= act_n;
      over_red    <= act_n ? scaled.r : 4'h0;
      over_green  <= act_n ? scaled.g : 4'h0;
      over_blue   <= act_n ? scaled.b : 4'h0;
    end
  end

endmodule

// File: tb/tb_over_screen_ctrl.sv
// Randomized + directed bench for over_screen_ctrl. A frame-count based model
// (level = base +/- frames/STEP) predicts every output each cycle; directed
// literal checks pin the model at known points of the fade timeline.
module tb_over_screen_ctrl;
  localparam int IMG_W = 256, IMG_H = 64, X0 = 192, Y0 = 208;
  localparam int STEP = 4, BLINK = 30, TRANSP = 0, FL = 6;

  logic        Clk = 0, Reset = 1, game_over = 0, restart_key = 0, frame_start = 0;
  logic [9:0]  DrawX = 0, DrawY = 0;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data = 0, pal_index, over_red, over_green, over_blue;
  logic [11:0] pal_rgb;
  logic        over_active, restart_req;

  over_screen_ctrl dut (
    .Clk(Clk), .Reset(Reset), .game_over(game_over), .restart_key(restart_key),
    .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
    .rom_data(rom_data), .pal_index(pal_index), .pal_rgb(pal_rgb),
    .over_red(over_red), .over_green(over_green), .over_blue(over_blue),
    .over_active(over_active), .restart_req(restart_req)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM (1-cycle synchronous) and combinational palette.
  logic [3:0]  mem [0:16383];
  logic [11:0] pal [0:15];
  always @(posedge Clk) rom_data <= mem[rom_addr];
  assign pal_rgb = pal[pal_index];

  int n_chk = 0, n_err = 0;
  bit chk_en = 0;

  // Pixel/frame driver.
  bit      pin_en = 0;
  int      pin_x = 0, pin_y = 0, fs_cnt = 0;
  always @(negedge Clk) begin
    frame_start = (fs_cnt == 0);
    fs_cnt = (fs_cnt + 1) % FL;
    if (pin_en) begin
      DrawX = 10'(pin_x);
      DrawY = 10'(pin_y);
    end else begin
      DrawX = 10'(X0 - 8 + int'($urandom_range(0, IMG_W + 15)));
      DrawY = 10'(Y0 - 4 + int'($urandom_range(0, IMG_H + 7)));
    end
  end

  // ---------------- Behavioural model ----------------
  // States: 0 idle, 1 fading in, 2 holding, 3 fading out.
  int m_st = 0, m_base = 0, m_frames = 0;
  bit m_go = 0;
  bit h_win [2];
  int h_addr [2];
  logic [13:0] e_addr = 0;
  logic [3:0]  e_r = 0, e_g = 0, e_b = 0;
  logic        e_act = 0, e_req = 0;

  function automatic int lvl_of(int st, int base, int fr);
    int v;
    case (st)
      0: v = 0;
      1: v = (base + fr / STEP > 16) ? 16 : base + fr / STEP;
      2: v = 16;
      default: v = (base - fr / STEP < 0) ? 0 : base - fr / STEP;
    endcase
    return v;
  endfunction

  function automatic bit blink_of(int st, int fr);
`ifdef OVER_BLINK_EN
    return (st != 2) || ((fr / BLINK) % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_st = 0; m_base = 0; m_frames = 0; m_go = 0;
      h_win[0] = 0; h_win[1] = 0; h_addr[0] = 0; h_addr[1] = 0;
      e_addr = 0; e_r = 0; e_g = 0; e_b = 0; e_act = 0; e_req = 0;
    end else begin
      int lvl, idx, rgb, px, py, a;
      bit bl, rise, fall, w;
      lvl = lvl_of(m_st, m_base, m_frames);
      bl  = blink_of(m_st, m_frames);
      idx = int'(mem[h_addr[1]]);
      rgb = int'(pal[idx]);
      e_act = h_win[1] && m_st != 0 && idx != TRANSP && bl;
      e_r = e_act ? 4'(((rgb >> 8) & 15) * lvl / 16) : 4'h0;
      e_g = e_act ? 4'(((rgb >> 4) & 15) * lvl / 16) : 4'h0;
      e_b = e_act ? 4'((rgb & 15) * lvl / 16) : 4'h0;
      px = int'(DrawX); py = int'(DrawY);
      w  = px >= X0 && px < X0 + IMG_W && py >= Y0 && py < Y0 + IMG_H;
      a  = w ? (py - Y0) * IMG_W + (px - X0) : 0;
      h_win[1] = h_win[0]; h_addr[1] = h_addr[0];
      h_win[0] = w; h_addr[0] = a;
      e_addr = 14'(a);
      rise = game_over && !m_go;
      fall = !game_over && m_go;
      e_req = 0;
      case (m_st)
        0: if (rise) begin m_st = 1; m_base = 0; m_frames = 0; end
        1: if (fall) begin m_st = 3; m_base = lvl; m_frames = 0; end
           else if (frame_start) begin
             m_frames++;
             if (m_frames % STEP == 0 && lvl_of(1, m_base, m_frames) >= 16) begin
               m_st = 2; m_frames = 0;
             end
           end
        2: if (restart_key || fall) begin m_st = 3; m_base = 16; m_frames = 0; end
           else if (frame_start) m_frames++;
        default: if (frame_start) begin
             m_frames++;
             if (m_frames % STEP == 0 && lvl_of(3, m_base, m_frames) == 0) begin
               m_st = 0; m_base = 0; m_frames = 0; e_req = 1;
             end
           end
      endcase
      m_go = game_over;
    end
  end

  // Per-cycle compare.
  always @(negedge Clk) begin
    if (chk_en) begin
      n_chk++;
      if (rom_addr !== e_addr || over_red !== e_r || over_green !== e_g ||
          over_blue !== e_b || over_active !== e_act || restart_req !== e_req) begin
        n_err++;
        $display("FAIL cycle t=%0t addr %0d want %0d rgb %h%h%h want %h%h%h act %b want %b req %b want %b",
                 $time, rom_addr, e_addr, over_red, over_green, over_blue, e_r, e_g, e_b,
                 over_active, e_act, restart_req, e_req);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge Clk);
      if (frame_start) c++;
    end
  endtask

  task automatic pin(input int px, input int py);
    pin_en = 1; pin_x = px; pin_y = py;
  endtask

  task automatic settle();
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic key_pulse();
    @(negedge Clk) restart_key = 1;
    @(posedge Clk);
    @(negedge Clk) restart_key = 0;
  endtask

  initial begin
    int f, pulses, fr_at, z, tog;
    bit prev;
    for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) pal[i] = 12'($urandom_range(0, 4095));
    mem[0] = 4'd1; mem[1] = 4'd0; mem[2] = 4'd2;
    pal[1] = 12'hF00; pal[2] = 12'h000;

    repeat (3) @(negedge Clk);
    #1;
    lit("reset_red", int'(over_red), 0);
    lit("reset_active", int'(over_active), 0);
    lit("reset_req", int'(restart_req), 0);
    lit("reset_addr", int'(rom_addr), 0);
    @(negedge Clk) Reset = 0;
    chk_en = 1;

    // Address generation.
    pin(X0 + 5, Y0 + 2);  repeat (2) @(posedge Clk); #1 lit("addr_517", int'(rom_addr), 517);
    pin(X0 + 255, Y0 + 63); repeat (2) @(posedge Clk); #1 lit("addr_last", int'(rom_addr), 16383);
    pin(X0 + IMG_W, Y0);  repeat (2) @(posedge Clk); #1 lit("addr_outside", int'(rom_addr), 0);

    // Fade in at the sprite origin (index 1 -> F00).
    pin(X0, Y0);
    @(negedge Clk) game_over = 1;
    @(posedge Clk);
    wait_frames(32);
    settle();
    lit("lvl8_red", int'(over_red), 7);
    lit("lvl8_green", int'(over_green), 0);
    lit("lvl8_active", int'(over_active), 1);
    wait_frames(32);
    settle();
    lit("lvl16_red", int'(over_red), 15);

    pin(X0 + 1, Y0); settle();
    lit("transp_active", int'(over_active), 0);
    lit("transp_red", int'(over_red), 0);
    pin(X0 + 2, Y0); settle();
    lit("black_active", int'(over_active), 1);
    lit("black_rgb", int'({over_red, over_green, over_blue}), 0);
    pin(X0 + IMG_W, Y0); settle();
    lit("outside_active", int'(over_active), 0);

    // HOLD display over 70 frames.
    pin(X0, Y0); settle();
    z = 0; tog = 0; prev = over_active;
    for (int i = 0; i < 70 * FL; i++) begin
      @(posedge Clk); #1;
      if (!over_active) z++;
      if (over_active != prev) tog++;
      prev = over_active;
    end
`ifdef OVER_BLINK_EN
    lit("blink_toggles", int'(tog >= 2), 1);
`else
    lit("hold_steady", z, 0);
`endif

    // Restart: fade out takes exactly 64 frames, one restart_req pulse.
    key_pulse();
    f = 0; pulses = 0; fr_at = -1;
    for (int i = 0; i < 100 * FL; i++) begin
      @(posedge Clk);
      if (frame_start) f++;
      #1;
      if (restart_req) begin pulses++; fr_at = f; end
    end
    lit("req_pulses", pulses, 1);
    lit("req_frame", fr_at, 64);
    z = 0;
    for (int i = 0; i < 10 * FL; i++) begin
      @(posedge Clk); #1;
      if (over_active || restart_req) z++;
    end
    lit("no_retrigger", z, 0);

    // Reset mid fade-out at level 9.
    @(negedge Clk) game_over = 0;
    @(negedge Clk) game_over = 1;
    @(posedge Clk);
    wait_frames(64);
    key_pulse();
    wait_frames(28);
    repeat (3) @(posedge Clk);
    #1 lit("lvl9_red", int'(over_red), 8);
    @(negedge Clk);
    #2 Reset = 1;
    #1;
    lit("async_red", int'(over_red), 0);
    lit("async_active", int'(over_active), 0);
    lit("async_req", int'(restart_req), 0);
    lit("async_addr", int'(rom_addr), 0);
    @(negedge Clk) Reset = 0;

    // Random phase.
    pin_en = 0;
    for (int k = 0; k < 10; k++) begin
      int hold;
      @(negedge Clk) game_over = ~game_over;
      hold = int'($urandom_range(100, 700));
      for (int i = 0; i < hold; i++) begin
        @(negedge Clk) restart_key = ($urandom_range(0, 39) == 0);
      end
      restart_key = 0;
    end
    repeat (4) @(negedge Clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
